seg7_scan_driver: RTL

Multiplexed N-digit seven-segment display driver, the parametrised successor to the single-digit BCD decoder. It captures an N-digit BCD word through a load strobe and double-buffers it so updates apply only at frame boundaries (no tearing). It time-multiplexes the digits onto one shared segment bus with a programmable refresh prescaler. It sits between the counter/datapath logic and the board's common-anode display pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 25 ++
 rtl/seg7_scan_driver.sv | 108 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, segment type and limits shared by the seven-segment scan driver
package seg7_pkg;
  localparam int MAX_DIGITS = 8;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;
  // Patterns are stored active-low; flip them for active-high boards.
  function automatic seg_t seg_pol(input seg_t s, input logic active_low);
    return active_low ? s : ~s;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD code to active-low segment pattern, codes 10-15 blank
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  output seg_t       o_seg
);
  // Table lookup; anything outside 0-9 lights nothing.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered N-digit multiplexed seven-segment driver; SEG7_LZ_BLANK_EN adds leading-zero blanking
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    pending,
  output logic [NUM_DIGITS-1:0]   an,
  output seg_t                    seg,
  output logic                    dp
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
  localparam logic AL = ACTIVE_LOW != 0;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_dig, r_disp_dig;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_disp_dp;
  logic                    r_pending;
  logic [NUM_DIGITS-1:0]   r_an;
  seg_t                    r_seg;
  logic                    r_dp;
  logic                    w_tick, w_frame, w_dp_sel, w_blank;
  logic [3:0]              w_code;
  logic [NUM_DIGITS-1:0]   w_an, w_lz;
  seg_t                    w_dec;
  assign w_tick  = r_cnt == LAST_CNT;
  assign w_frame = w_tick && r_idx == LAST_IDX;
  assign pending = r_pending;
  assign an      = r_an;
  assign seg     = r_seg;
  assign dp      = r_dp;
`ifdef SEG7_LZ_BLANK_EN
  logic w_hi_zero;
  // Digit i>0 is a leading zero when it and every digit above it is zero; digit 0 always shows.
  always_comb begin
    w_lz = '0;
    w_hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_hi_zero = w_hi_zero && r_disp_dig[4*i +: 4] == 4'd0;
      w_lz[i] = w_hi_zero;
    end
  end
`else
  assign w_lz = '0;
`endif
  // Select the scanned digit's code, dp bit and blank flag, and build the one-cold anode enable.
  always_comb begin
    w_code = '0;
    w_dp_sel = 1'b0;
    w_blank = 1'b0;
    w_an = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_code = r_disp_dig[4*i +: 4];
        w_dp_sel = r_disp_dp[i];
        w_blank = w_lz[i];
        w_an[i] = 1'b0;
      end
    end
  end
  seg7_decode u_dec (.i_code(w_code), .o_seg(w_dec));
  // Prescaler, digit index and the shadow/display double buffer; a load on a commit edge stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sh_dig <= '0;
      r_sh_dp <= '0;
      r_disp_dig <= '0;
      r_disp_dp <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= r_idx == LAST_IDX ? '0 : r_idx + 1'b1;
      if (w_frame && r_pending) begin
        r_disp_dig <= r_sh_dig;
        r_disp_dp <= r_sh_dp;
      end
      if (load) begin
        r_sh_dig <= digits_in;
        r_sh_dp <= dp_in;
      end
      r_pending <= load || (r_pending && !w_frame);
    end
  end
  // Registered pin drivers; reset forces every digit and segment dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an <= '1;
      r_seg <= seg_pol(SEG_BLANK, AL);
      r_dp <= AL;
    end else begin
      r_an <= w_an;
      r_seg <= seg_pol(w_blank ? SEG_BLANK : w_dec, AL);
      r_dp <= w_dp_sel ^ AL;
    end
  end
endmodule
